// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch queue.
//   XLEN_DEF      default PC / instruction width
//   DEPTH_DEF     default fetch-queue entry count (power of two, >= 2)
//   RESET_PC_DEF  default first fetch address after reset
//   PC_STEP_DEF   default sequential PC increment
//   fetch_entry_t one queue entry at the default width: {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int                    XLEN_DEF     = 32;
    localparam int                    DEPTH_DEF    = 4;
    localparam logic [XLEN_DEF-1:0]   RESET_PC_DEF = '0;
    localparam int                    PC_STEP_DEF  = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous in-order FIFO holding fetched {pc, instr} entries.
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous active-low reset (clears pointers and count)
//   i_push   write i_wdata at the tail
//   i_pop    retire the head entry
//   i_flush  discard all entries (wins over push/pop)
//   i_wdata  tail write data
//   o_rdata  head entry (combinational view of the storage)
//   o_count  number of entries held
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the natural binary overflow the modulo-DEPTH wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; the head is only observed when count != 0.
    always_ff @(posedge clock) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Instruction fetch front end: issues sequential fetches to instruction
// memory (one outstanding at a time), queues returned instructions in order
// and presents the head entry to the consumer.
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   stall            consumer does not take the head entry this cycle
//   redirect         restart fetch at pc_branch_in, flushing the queue
//   pc_branch_in     redirect target
//   imem_req         fetch request (accepted by memory in the same cycle)
//   imem_addr        fetch address
//   imem_rvalid      returned data valid
//   imem_rdata       returned instruction
//   valid_out        head entry valid
//   pc_out           head entry PC (0 while valid_out = 0)
//   instruction_out  head entry instruction (0 while valid_out = 0)
// -----------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  pc_branch_in,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             valid_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  instruction_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Same layout as fetch_entry_t, sized by XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_outstanding;
    logic            r_epoch;
    logic            r_req_epoch;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_reserved;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_valid;
    entry_t          w_wr_entry;
    entry_t          w_head;

    // Slots already spoken for: queued entries plus the one in flight. Issuing
    // only while this is below DEPTH means every response has a free slot.
    assign w_reserved = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding};

    // A response arriving this cycle frees the single request slot, so a new
    // fetch may go out back-to-back. Gated by reset so the request drops
    // immediately while reset is held.
    assign w_issue = reset & ~redirect & (~r_outstanding | imem_rvalid)
                   & (w_reserved < (CW+1)'(DEPTH));

    assign w_resp  = imem_rvalid & r_outstanding;
    assign w_push  = ~redirect & w_resp & (r_req_epoch == r_epoch);
    assign w_valid = reset & (w_count != '0) & ~redirect;
    assign w_pop   = w_valid & ~stall;

    assign w_wr_entry.pc    = r_req_addr;
    assign w_wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
            r_epoch       <= 1'b0;
            r_req_epoch   <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc  <= pc_branch_in;
            r_epoch     <= ~r_epoch;
            // Tag any in-flight request with the retiring epoch so it can
            // never match again, even after several back-to-back redirects.
            r_req_epoch <= r_epoch;
            // A response landing in the redirect cycle completes the request
            // (its data is dropped); otherwise it stays in flight as stale.
            if (imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
        end else if (w_issue) begin
            r_outstanding <= 1'b1;
            r_req_addr    <= r_fetch_pc;
            r_req_epoch   <= r_epoch;
            r_fetch_pc    <= r_fetch_pc + XLEN'(PC_STEP);
        end else if (w_resp) begin
            r_outstanding <= 1'b0;
        end
    end

    assign imem_req        = w_issue;
    assign imem_addr       = r_fetch_pc;
    assign valid_out       = w_valid;
    assign pc_out          = w_valid ? w_head.pc    : '0;
    assign instruction_out = w_valid ? w_head.instr : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
// Self-checking bench for fetch_queue_unit: a directed vector table, a few
// hand-written corner sequences and randomized traffic, all checked against a
// queue-based reference model and a latency-configurable memory model.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pc_branch_in = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    fetch_queue_unit #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .pc_branch_in(pc_branch_in), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_out(valid_out),
        .pc_out(pc_out), .instruction_out(instruction_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int    mem_lat = 1;
    int    cyc = 0;
    bit    spurious_en = 0;

    // ---------------- reference model ----------------
    fetch_entry_t mq[$];
    logic [31:0]  m_pc = '0;
    logic [31:0]  m_addr = '0;
    bit           m_busy = 0;
    bit           m_stale = 0;
    logic [31:0]  popped[$];

    // ---------------- vector table ----------------
    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] b;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;
    vec_t tbl[$];
    vec_t cur_tv;
    bit   tv_on = 0;

    function automatic vec_t tv(input logic s, input logic r, input logic [31:0] b,
                                input logic ev, input logic [31:0] epc,
                                input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.s = s; v.r = r; v.b = b; v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic mem_drive(output bit rv, output logic [31:0] rd);
        rv = 0;
        rd = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            rv = 1;
            rd = mem_q[0].addr ^ MAGIC;
            void'(mem_q.pop_front());
        end else if (spurious_en && mem_q.size() == 0 && !m_busy && $urandom_range(0, 9) == 0) begin
            rv = 1;
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] b);
        bit           rv;
        logic [31:0]  rd;
        bit           exp_valid;
        bit           exp_req;
        fetch_entry_t e;
        stall = s; redirect = r; pc_branch_in = b;
        mem_drive(rv, rd);
        #1;
        exp_valid = (mq.size() != 0) && !r;
        exp_req   = !r && (!m_busy || rv) && ((mq.size() + int'(m_busy)) < DEPTH);
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("pc_out", pc_out, exp_valid ? mq[0].pc : 32'h0);
        chk("instruction_out", instruction_out, exp_valid ? mq[0].instr : 32'h0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (tv_on) begin
            chk("tv_valid", 32'(valid_out), 32'(cur_tv.ev));
            chk("tv_pc", pc_out, cur_tv.ev ? cur_tv.epc : 32'h0);
            chk("tv_instr", instruction_out, cur_tv.ev ? (cur_tv.epc ^ MAGIC) : 32'h0);
            chk("tv_req", 32'(imem_req), 32'(cur_tv.ereq));
            if (cur_tv.ereq) chk("tv_addr", imem_addr, cur_tv.eaddr);
        end
        if (valid_out && !s) popped.push_back(pc_out);
        if (imem_req) mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
        // model update for the coming edge
        if (r) begin
            mq.delete();
            m_pc = b;
            if (m_busy && !rv) m_stale = 1;
            else begin m_busy = 0; m_stale = 0; end
        end else begin
            if (exp_valid && !s) void'(mq.pop_front());
            if (rv && m_busy) begin
                if (!m_stale) begin
                    e.pc = m_addr; e.instr = rd;
                    mq.push_back(e);
                end
                m_busy = 0; m_stale = 0;
            end
            if (exp_req) begin
                m_busy = 1; m_stale = 0; m_addr = m_pc; m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic model_clear();
        mq.delete(); m_pc = '0; m_busy = 0; m_stale = 0;
    endtask

    task automatic hard_reset(input int lat);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instruction_out, 32'h0);
        @(posedge clock);
        @(negedge clock);
        mem_q.delete(); model_clear(); popped.delete();
        cyc = 0; mem_lat = lat;
        reset = 1'b1;
    endtask

    initial begin
        bit found;
        @(negedge clock);

        // ---- directed table: free run, stall/hold/drain, wrap redirect ----
        tbl.push_back(tv(0, 0, 0, 0, 0, 1, 32'd0));
        tbl.push_back(tv(0, 0, 0, 0, 0, 1, 32'd4));
        tbl.push_back(tv(0, 0, 0, 1, 32'd0, 1, 32'd8));
        tbl.push_back(tv(0, 0, 0, 1, 32'd4, 1, 32'd12));
        tbl.push_back(tv(1, 0, 0, 1, 32'd8, 1, 32'd16));
        tbl.push_back(tv(1, 0, 0, 1, 32'd8, 1, 32'd20));
        for (int i = 6; i <= 13; i++) tbl.push_back(tv(1, 0, 0, 1, 32'd8, 0, 0));
        tbl.push_back(tv(0, 0, 0, 1, 32'd8, 0, 0));
        tbl.push_back(tv(0, 0, 0, 1, 32'd12, 1, 32'd24));
        tbl.push_back(tv(0, 0, 0, 1, 32'd16, 1, 32'd28));
        tbl.push_back(tv(0, 0, 0, 1, 32'd20, 1, 32'd32));
        tbl.push_back(tv(0, 0, 0, 1, 32'd24, 1, 32'd36));
        tbl.push_back(tv(0, 0, 0, 1, 32'd28, 1, 32'd40));
        tbl.push_back(tv(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));
        tbl.push_back(tv(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC));
        tbl.push_back(tv(0, 0, 0, 0, 0, 1, 32'h0));
        tbl.push_back(tv(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'd4));
        tbl.push_back(tv(0, 0, 0, 1, 32'h0, 1, 32'd8));

        hard_reset(1);
        tv_on = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            cur_tv = tbl[i];
            step(tbl[i].s, tbl[i].r, tbl[i].b);
        end
        tv_on = 0;

        // ---- latency 3, redirect while a request is in flight ----
        hard_reset(3);
        step(0, 0, 0);
        step(0, 1, 32'd32);
        for (int i = 0; i < 18; i++) step(0, 0, 0);
        chk("stale_count", 32'(popped.size() >= 3), 32'h1);
        for (int k = 0; k < 3 && k < popped.size(); k++)
            chk("stale_seq", popped[k], 32'd32 + 32'(4 * k));

        // ---- redirect + response + pop with reserved-full queue ----
        hard_reset(1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() == 3 && m_busy && mem_q.size() > 0 && mem_q[0].due == cyc) found = 1;
            else step(1, 0, 0);
        end
        chk("full_setup", 32'(found), 32'h1);
        popped.delete();
        step(0, 1, 32'h100);
        redirect = 1'b0; stall = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("flush_empty", 32'(valid_out), 32'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("flush_count", 32'(popped.size() > 0), 32'h1);
        for (int k = 0; k < popped.size(); k++)
            chk("no_stale", popped[k], 32'h100 + 32'(4 * k));

        // ---- reset mid-run with 3 entries queued, latency 2 ----
        hard_reset(2);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() == 3 && m_busy) found = 1;
            else step(1, 0, 0);
        end
        chk("mid_setup", 32'(found), 32'h1);
        begin
            bit          rv;
            logic [31:0] rd;
            reset = 1'b0; stall = 1'b0;
            mem_drive(rv, rd);
            #1;
            chk("mid_valid", 32'(valid_out), 32'h0);
            chk("mid_req", 32'(imem_req), 32'h0);
            chk("mid_pc", pc_out, 32'h0);
            chk("mid_instr", instruction_out, 32'h0);
            model_clear();
            @(posedge clock);
            @(negedge clock);
            cyc++;
            reset = 1'b1;
        end
        popped.delete();
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("resume_count", 32'(popped.size() > 0), 32'h1);
        if (popped.size() > 0) chk("resume_pc", popped[0], 32'h0);

        // ---- randomized traffic at latencies 1..3 ----
        for (int lat = 1; lat <= 3; lat++) begin
            hard_reset(lat);
            spurious_en = 1;
            for (int i = 0; i < 250; i++) begin
                logic [31:0] b;
                b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5), b);
            end
            spurious_en = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
